contador_vga: RTL and testbench
===============================

# contador_vga

Timing-base counter for the VGA output path. Divides the system clock into a pixel-rate tick and runs the horizontal pixel counter and vertical line counter for 640×480 at 60 Hz. It sits directly upstream of the vertical sync generator, which decodes the 10-bit line count `cuenta_v`. It also produces the horizontal sync and the visible-area flag for the pixel/colour stage.

## Interface
Parameters:
- `DIV`, 4: system clocks per pixel (100 MHz → 25 MHz); legal range 1..16.
- `H_VISIBLE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_VISIBLE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.

Ports:
- `clk` in 1: system clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `habilitar` in 1: run enable. While low, the divider and both counters hold their values.
- `tick_pixel` out 1: one-`clk` pulse, once every `DIV` enabled clocks.
- `cuenta_h` out 10: horizontal pixel index, 0..799.
- `cuenta_v` out 10: vertical line index, 0..524. Feeds the vsync generator.
- `hsinc` out 1: horizontal sync, active low.
- `video_on` out 1: high inside the visible area.
- `fin_linea` out 1: one-`clk` pulse on the tick that wraps `cuenta_h`.
- `fin_cuadro` out 1: one-`clk` pulse on the tick that wraps both counters.

## Operation
- Derived constants: H_TOTAL = 640+16+96+48 = 800; V_TOTAL = 480+10+2+33 = 525.
- Divider counter, `clog2(DIV)` bits:
  - Counts 0..DIV-1 while `habilitar` = 1.
  - `tick_pixel` = 1 while the divider count is DIV-1 and `habilitar` = 1.
  - If DIV = 1, `tick_pixel` equals `habilitar`.
- Horizontal counter, advances only on `clk` edges where `tick_pixel` = 1:
  - `cuenta_h` ← `cuenta_h`+1.
  - At H_TOTAL-1 (799) it wraps to 0 instead.
- Vertical counter, advances only on a tick where `cuenta_h` = 799:
  - `cuenta_v` ← `cuenta_v`+1.
  - At V_TOTAL-1 (524) it wraps to 0 instead.
- `hsinc` is a registered output.
  - It is 0 when the next `cuenta_h` is in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] = [656, 751].
  - Otherwise it is 1.
  - This keeps it aligned with `cuenta_h`: `hsinc` = 0 exactly while `cuenta_h` is in 656..751.
- `video_on` is combinational from the registered counts: (`cuenta_h` < 640) AND (`cuenta_v` < 480).
- `fin_linea` is combinational: `tick_pixel` AND (`cuenta_h` = 799).
- `fin_cuadro` is combinational: `fin_linea` AND (`cuenta_v` = 524).
- Vertical sync is not generated here. The downstream block decodes `cuenta_v`.
- Width rules:
  - All comparisons are unsigned on 10 bits.
  - Counters never hold values ≥ their total. Any out-of-range value (not reachable after reset) wraps to 0 on the next tick.

## Timing
- Reset, asynchronous on the falling edge of `reset`:
  - divider = 0, `cuenta_h` = 0, `cuenta_v` = 0, `hsinc` = 1.
  - Hence `tick_pixel` = 0, `video_on` = 1, `fin_linea` = 0, `fin_cuadro` = 0.
- First tick after reset release: `tick_pixel` rises in the DIV-th enabled cycle after release (cycle 4 for DIV = 4). `cuenta_h` becomes 1 on that edge.
- Latency: counter outputs change on the same edge that samples `tick_pixel` = 1. No added pipeline delay.
- Line period = 800×DIV clocks (3200). Frame period = 525×800×DIV clocks (1,680,000).
- `habilitar` deasserted mid-line: every register freezes and `tick_pixel` = 0. On reassertion, counting resumes from the frozen divider value, so no pixel is skipped or repeated.
- Simultaneous end-of-line and end-of-frame: on a single edge `cuenta_h` 799→0 and `cuenta_v` 524→0. `fin_linea` and `fin_cuadro` are both high for that one cycle.
- Reset asserted mid-frame: all outputs return immediately, without a clock, to the reset values above.

## Test plan
- Reset hold, then release with `habilitar` = 1 and DIV = 4 → `tick_pixel` pulses on cycles 4, 8, 12…; `cuenta_h` reads 1, 2, 3 after those edges; `hsinc` = 1; `video_on` = 1.
- Run one full line → `hsinc` falls when `cuenta_h` reaches 656 and rises at 752 (96 ticks low). `video_on` falls at `cuenta_h` = 640. `fin_linea` pulses once at 799. `cuenta_v` then increments 0→1.
- Run a full frame → `cuenta_v` goes 479→480 with `video_on` held 0 from then on. `fin_cuadro` pulses exactly once, on the edge where (799, 524) → (0, 0). Frame length is 1,680,000 clocks.
- Drop `habilitar` for 37 cycles at `cuenta_h` = 300 → all counters and `hsinc` remain frozen and `tick_pixel` = 0. On resume, `cuenta_h` reaches 301 after the remaining divider cycles.
- Assert `reset` asynchronously between clock edges at (h = 700, v = 490) → outputs go immediately to (0, 0), `hsinc` = 1, `fin_*` = 0, with no clock edge required.
- DIV = 1 variant → `tick_pixel` = `habilitar` every cycle; line period is 800 clocks; `hsinc` low for 96 clocks.

Source files
------------

// File: rtl/contador_vga.sv
// VGA timing base: pixel-rate divider plus horizontal/vertical position counters.
// Drives a registered hsinc and combinational visible-area and end-of-line/frame flags.
module contador_vga #(
  parameter int DIV       = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       habilitar,
  output logic       tick_pixel,
  output logic [9:0] cuenta_h,
  output logic [9:0] cuenta_v,
  output logic       hsinc,
  output logic       video_on,
  output logic       fin_linea,
  output logic       fin_cuadro
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);

  logic [9:0] cuenta_h_q, cuenta_h_d;
  logic [9:0] cuenta_v_q, cuenta_v_d;
  logic       hsinc_q, hsinc_d;
  logic       tick;

  generate
    if (DIV == 1) begin : g_sin_div
      assign tick = habilitar;
    end else begin : g_div
      localparam int DW = $clog2(DIV);
      localparam logic [DW-1:0] D_LAST = DW'(DIV - 1);
      logic [DW-1:0] div_q, div_d;

      always_comb begin
        div_d = div_q;
        if (habilitar) div_d = (div_q >= D_LAST) ? '0 : div_q + DW'(1);
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) div_q <= '0;
        else        div_q <= div_d;
      end

      assign tick = habilitar && (div_q == D_LAST);
    end
  endgenerate

  always_comb begin
    cuenta_h_d = cuenta_h_q;
    cuenta_v_d = cuenta_v_q;
    if (tick) begin
      cuenta_h_d = (cuenta_h_q >= H_LAST) ? '0 : cuenta_h_q + 10'd1;
      if (cuenta_h_q == H_LAST)
        cuenta_v_d = (cuenta_v_q >= V_LAST) ? '0 : cuenta_v_q + 10'd1;
      else if (cuenta_v_q > V_LAST)
        cuenta_v_d = '0;
    end
    // Decode from the next count so the registered sync lines up with cuenta_h.
    hsinc_d = !((cuenta_h_d >= HS_FIRST) && (cuenta_h_d <= HS_LAST));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cuenta_h_q <= '0;
      cuenta_v_q <= '0;
      hsinc_q    <= 1'b1;
    end else begin
      cuenta_h_q <= cuenta_h_d;
      cuenta_v_q <= cuenta_v_d;
      hsinc_q    <= hsinc_d;
    end
  end

  assign tick_pixel = tick;
  assign cuenta_h   = cuenta_h_q;
  assign cuenta_v   = cuenta_v_q;
  assign hsinc      = hsinc_q;
  assign video_on   = (cuenta_h_q < H_VIS) && (cuenta_v_q < V_VIS);
  assign fin_linea  = tick && (cuenta_h_q == H_LAST);
  assign fin_cuadro = fin_linea && (cuenta_v_q == V_LAST);
endmodule

// File: tb/tb_contador_vga.sv
// Bench for contador_vga: default timing (DIV=4), DIV=1 default timing, and a shrunken DIV=2 frame.
module tb_contador_vga;
  typedef struct packed {
    logic       tick;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       von;
    logic       fl;
    logic       fc;
  } obs_t;

  logic clk, reset, habilitar;
  logic a_tick, a_hs, a_von, a_fl, a_fc;
  logic b_tick, b_hs, b_von, b_fl, b_fc;
  logic c_tick, c_hs, c_von, c_fl, c_fc;
  logic [9:0] a_h, a_v, b_h, b_v, c_h, c_v;
  obs_t oa, ob, oc;
  obs_t exp_q[$];
  int checks, errors;

  localparam obs_t RST = '{tick: 1'b0, h: 10'd0, v: 10'd0, hs: 1'b1, von: 1'b1, fl: 1'b0, fc: 1'b0};

  contador_vga dut_a (
    .clk(clk), .reset(reset), .habilitar(habilitar), .tick_pixel(a_tick),
    .cuenta_h(a_h), .cuenta_v(a_v), .hsinc(a_hs), .video_on(a_von),
    .fin_linea(a_fl), .fin_cuadro(a_fc));

  contador_vga #(.DIV(1)) dut_b (
    .clk(clk), .reset(reset), .habilitar(habilitar), .tick_pixel(b_tick),
    .cuenta_h(b_h), .cuenta_v(b_v), .hsinc(b_hs), .video_on(b_von),
    .fin_linea(b_fl), .fin_cuadro(b_fc));

  // 24 pixels x 10 lines so a whole frame fits in a short run.
  contador_vga #(.DIV(2), .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                 .V_VISIBLE(6), .V_FP(1), .V_SYNC(1), .V_BP(2)) dut_c (
    .clk(clk), .reset(reset), .habilitar(habilitar), .tick_pixel(c_tick),
    .cuenta_h(c_h), .cuenta_v(c_v), .hsinc(c_hs), .video_on(c_von),
    .fin_linea(c_fl), .fin_cuadro(c_fc));

  assign oa = {a_tick, a_h, a_v, a_hs, a_von, a_fl, a_fc};
  assign ob = {b_tick, b_h, b_v, b_hs, b_von, b_fl, b_fc};
  assign oc = {c_tick, c_h, c_v, c_hs, c_von, c_fl, c_fc};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after n enabled clock edges since reset release.
  function automatic obs_t exp_gen(int n, int dv, int ht, int vt, int hvis, int vvis, int hs0, int hs1);
    obs_t o;
    int p, h, v;
    p = n / dv;
    h = p % ht;
    v = (p / ht) % vt;
    o.h   = 10'(h);
    o.v   = 10'(v);
    o.tick = ((n % dv) == dv - 1);
    o.hs  = !(h >= hs0 && h <= hs1);
    o.von = (h < hvis) && (v < vvis);
    o.fl  = o.tick && (h == ht - 1);
    o.fc  = o.fl && (v == vt - 1);
    return o;
  endfunction

  function automatic obs_t exp_a(int n); return exp_gen(n, 4, 800, 525, 640, 480, 656, 751); endfunction
  function automatic obs_t exp_b(int n); return exp_gen(n, 1, 800, 525, 640, 480, 656, 751); endfunction
  function automatic obs_t exp_c(int n); return exp_gen(n, 2, 24, 10, 16, 6, 18, 20); endfunction

  task automatic start();
    @(negedge clk);
    reset = 1'b0;
    habilitar = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    obs_t rb;
    reset = 1'b1;
    habilitar = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    exp_q.push_back(RST);
    exp_q.push_back(RST);
    exp_q.push_back(RST);
    checks++; if (oa !== exp_q[0]) begin errors++; $display("FAIL reset_a got %h exp %h", oa, exp_q[0]); end
    checks++; if (ob !== exp_q[1]) begin errors++; $display("FAIL reset_b got %h exp %h", ob, exp_q[1]); end
    checks++; if (oc !== exp_q[2]) begin errors++; $display("FAIL reset_c got %h exp %h", oc, exp_q[2]); end
    exp_q.delete();
    habilitar = 1'b1;
    #1;
    rb = RST;
    rb.tick = 1'b1;
    checks++; if (ob !== rb) begin errors++; $display("FAIL reset_b_tick got %h exp %h", ob, rb); end
    checks++; if (a_tick !== 1'b0) begin errors++; $display("FAIL reset_a_tick got %b exp 0", a_tick); end
  endtask

  task automatic test_first_ticks();
    obs_t e;
    start();
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk);
      exp_q.push_back(exp_a(n));
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (oa !== e) begin
        errors++;
        $display("FAIL first_ticks n=%0d got tick=%b h=%0d hs=%b exp tick=%b h=%0d hs=%b", n, oa.tick, oa.h, oa.hs, e.tick, e.h, e.hs);
      end
    end
  endtask

  task automatic test_line();
    obs_t e;
    int hs_low, fl_cnt, fl_n;
    hs_low = 0; fl_cnt = 0; fl_n = -1;
    start();
    for (int n = 1; n <= 3210; n++) begin
      @(posedge clk);
      exp_q.push_back(exp_a(n));
      @(negedge clk);
      e = exp_q.pop_front();
      if (n <= 3200 && !a_hs) hs_low++;
      if (n <= 3200 && a_fl) begin fl_cnt++; fl_n = n; end
      checks++;
      if (oa !== e) begin
        errors++;
        $display("FAIL line n=%0d got %h (h=%0d v=%0d) exp %h (h=%0d v=%0d)", n, oa, oa.h, oa.v, e, e.h, e.v);
      end
    end
    checks++; if (hs_low != 384) begin errors++; $display("FAIL line_hs_low got %0d exp 384", hs_low); end
    checks++; if (fl_cnt != 1 || fl_n != 3199) begin errors++; $display("FAIL line_fin_linea got cnt=%0d at=%0d exp cnt=1 at=3199", fl_cnt, fl_n); end
    checks++; if (a_v !== 10'd1) begin errors++; $display("FAIL line_v got %0d exp 1", a_v); end
  endtask

  task automatic test_frame();
    obs_t e;
    int fc_cnt, fc0, fc1;
    fc_cnt = 0; fc0 = -1; fc1 = -1;
    start();
    for (int n = 1; n <= 970; n++) begin
      @(posedge clk);
      exp_q.push_back(exp_c(n));
      @(negedge clk);
      e = exp_q.pop_front();
      if (c_fc) begin
        if (fc_cnt == 0) fc0 = n; else fc1 = n;
        fc_cnt++;
      end
      checks++;
      if (oc !== e) begin
        errors++;
        $display("FAIL frame n=%0d got %h (h=%0d v=%0d) exp %h (h=%0d v=%0d)", n, oc, oc.h, oc.v, e, e.h, e.v);
      end
    end
    checks++; if (fc_cnt != 2 || fc0 != 479) begin errors++; $display("FAIL frame_fc got cnt=%0d first=%0d exp cnt=2 first=479", fc_cnt, fc0); end
    checks++; if (fc1 - fc0 != 480) begin errors++; $display("FAIL frame_len got %0d exp 480", fc1 - fc0); end
  endtask

  task automatic test_hold();
    obs_t e, f;
    start();
    for (int n = 1; n <= 1203; n++) begin
      @(posedge clk);
      exp_q.push_back(exp_a(n));
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (oa !== e) begin errors++; $display("FAIL hold_pre n=%0d got %h exp %h", n, oa, e); end
    end
    habilitar = 1'b0;
    f = exp_a(1203);
    f.tick = 1'b0; f.fl = 1'b0; f.fc = 1'b0;
    for (int k = 0; k < 37; k++) begin
      @(posedge clk);
      exp_q.push_back(f);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (oa !== e) begin errors++; $display("FAIL hold_frozen k=%0d got tick=%b h=%0d exp tick=%b h=%0d", k, oa.tick, oa.h, e.tick, e.h); end
    end
    habilitar = 1'b1;
    for (int n = 1204; n <= 1212; n++) begin
      @(posedge clk);
      exp_q.push_back(exp_a(n));
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (oa !== e) begin errors++; $display("FAIL hold_resume n=%0d got h=%0d tick=%b exp h=%0d tick=%b", n, oa.h, oa.tick, e.h, e.tick); end
    end
  endtask

  task automatic test_async_reset();
    obs_t e;
    start();
    for (int n = 1; n <= 376; n++) begin
      @(posedge clk);
      exp_q.push_back(exp_c(n));
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (oc !== e) begin errors++; $display("FAIL async_pre n=%0d got %h exp %h", n, oc, e); end
    end
    checks++;
    if (c_h !== 10'd20 || c_v !== 10'd7 || c_hs !== 1'b0) begin
      errors++; $display("FAIL async_pos got h=%0d v=%0d hs=%b exp h=20 v=7 hs=0", c_h, c_v, c_hs);
    end
    #2 reset = 1'b0;
    #1;
    exp_q.push_back(RST);
    exp_q.push_back(RST);
    e = exp_q.pop_front();
    checks++; if (oc !== e) begin errors++; $display("FAIL async_c got %h exp %h", oc, e); end
    e = exp_q.pop_front();
    checks++; if (oa !== e) begin errors++; $display("FAIL async_a got %h exp %h", oa, e); end
  endtask

  task automatic test_div1();
    obs_t e;
    int hs_low, fl0, fl1;
    hs_low = 0; fl0 = -1; fl1 = -1;
    start();
    for (int n = 1; n <= 1610; n++) begin
      @(posedge clk);
      exp_q.push_back(exp_b(n));
      @(negedge clk);
      e = exp_q.pop_front();
      if (n <= 800 && !b_hs) hs_low++;
      if (b_fl) begin if (fl0 < 0) fl0 = n; else fl1 = n; end
      checks++;
      if (ob !== e) begin errors++; $display("FAIL div1 n=%0d got %h (h=%0d) exp %h (h=%0d)", n, ob, ob.h, e, e.h); end
    end
    checks++; if (hs_low != 96) begin errors++; $display("FAIL div1_hs_low got %0d exp 96", hs_low); end
    checks++; if (fl0 != 799 || fl1 - fl0 != 800) begin errors++; $display("FAIL div1_period got first=%0d period=%0d exp 799 800", fl0, fl1 - fl0); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    habilitar = 1'b0;
    test_reset();
    test_first_ticks();
    test_line();
    test_frame();
    test_hold();
    test_async_reset();
    test_div1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
